// File: rtl/oblique_tree_engine.sv
// Oblique decision-tree inference engine: walks a node RAM, taking a signed
// dot product of the latched feature vector against each node's coefficients.

module otree_mac_lane #(
  parameter int FEAT_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int OUT_WIDTH  = 20
) (
  input  logic [FEAT_WIDTH-1:0] feat,
  input  logic [COEF_WIDTH-1:0] coef,
  output logic [OUT_WIDTH-1:0]  prod
);
  logic signed [OUT_WIDTH-1:0] f_ext, c_ext;

  // Feature is unsigned, coefficient is two's complement; the product fits OUT_WIDTH.
  assign f_ext = {{(OUT_WIDTH-FEAT_WIDTH){1'b0}}, feat};
  assign c_ext = {{(OUT_WIDTH-COEF_WIDTH){coef[COEF_WIDTH-1]}}, coef};
  assign prod  = f_ext * c_ext;
endmodule

module oblique_tree_engine #(
  parameter int NUM_FEATURES = 5,
  parameter int FEAT_WIDTH   = 8,
  parameter int COEF_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 6,
  parameter int CLASS_WIDTH  = 4,
  parameter int MAX_DEPTH    = 16,
  parameter int ACC_WIDTH    = FEAT_WIDTH + 1 + COEF_WIDTH + $clog2(NUM_FEATURES),
  parameter int NODE_WIDTH   = 1 + NUM_FEATURES*COEF_WIDTH + ACC_WIDTH + 2*ADDR_WIDTH,
  parameter int DEPTH_WIDTH  = $clog2(MAX_DEPTH+1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] in_features,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CLASS_WIDTH-1:0]             out_class,
  output logic                               out_err,
  output logic [DEPTH_WIDTH-1:0]             out_depth,
  input  logic                               cfg_we,
  input  logic [ADDR_WIDTH-1:0]              cfg_addr,
  input  logic [NODE_WIDTH-1:0]              cfg_wdata,
  output logic                               cfg_drop
);
  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int RIGHT_LSB = 0;
  localparam int LEFT_LSB  = ADDR_WIDTH;
  localparam int THR_LSB   = 2*ADDR_WIDTH;
  localparam int COEF_LSB  = THR_LSB + ACC_WIDTH;
  localparam int LEAF_BIT  = NODE_WIDTH - 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EVAL  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                                state;
  logic [ADDR_WIDTH-1:0]                     addr_q;
  logic [DEPTH_WIDTH-1:0]                    depth_q, depth_nxt;
  logic [NUM_FEATURES-1:0][FEAT_WIDTH-1:0]   feat_q;
  logic [NODE_WIDTH-1:0]                     mem [RAM_DEPTH];
  logic [NODE_WIDTH-1:0]                     node_q;
  logic [NUM_FEATURES-1:0][ACC_WIDTH-1:0]    prod;
  logic signed [ACC_WIDTH-1:0]               sum, thr;
  logic                                      is_leaf, go_left;
  logic [ADDR_WIDTH-1:0]                     left_addr, right_addr;

  // Node RAM: writes only while idle, registered read of the current walk address.
  always_ff @(posedge clk) begin
    if (cfg_we && state == S_IDLE) mem[cfg_addr] <= cfg_wdata;
    node_q <= mem[addr_q];
  end

  genvar g;
  generate
    for (g = 0; g < NUM_FEATURES; g++) begin : g_lane
      otree_mac_lane #(
        .FEAT_WIDTH(FEAT_WIDTH),
        .COEF_WIDTH(COEF_WIDTH),
        .OUT_WIDTH (ACC_WIDTH)
      ) u_lane (
        .feat(feat_q[g]),
        .coef(node_q[COEF_LSB + g*COEF_WIDTH +: COEF_WIDTH]),
        .prod(prod[g])
      );
    end
  endgenerate

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_FEATURES; i++) sum = sum + $signed(prod[i]);
  end

  assign thr        = node_q[THR_LSB +: ACC_WIDTH];
  assign is_leaf    = node_q[LEAF_BIT];
  assign left_addr  = node_q[LEFT_LSB +: ADDR_WIDTH];
  assign right_addr = node_q[RIGHT_LSB +: ADDR_WIDTH];
  // Ties go right.
  assign go_left    = sum < thr;
  assign depth_nxt  = depth_q + 1'b1;

  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      addr_q    <= '0;
      depth_q   <= '0;
      feat_q    <= '0;
      out_class <= '0;
      out_err   <= 1'b0;
      out_depth <= '0;
      cfg_drop  <= 1'b0;
    end else begin
      cfg_drop <= cfg_we && (state != S_IDLE);
      case (state)
        S_IDLE: if (in_valid) begin
          feat_q  <= in_features;
          addr_q  <= '0;
          depth_q <= '0;
          state   <= S_FETCH;
        end
        S_FETCH: state <= S_EVAL;
        S_EVAL: begin
          depth_q <= depth_nxt;
          if (is_leaf) begin
            out_class <= node_q[LEFT_LSB +: CLASS_WIDTH];
            out_err   <= 1'b0;
            out_depth <= depth_nxt;
            state     <= S_DONE;
          end else if (depth_nxt == DEPTH_WIDTH'(MAX_DEPTH)) begin
            out_class <= '0;
            out_err   <= 1'b1;
            out_depth <= depth_nxt;
            state     <= S_DONE;
          end else begin
            addr_q <= go_left ? left_addr : right_addr;
            state  <= S_FETCH;
          end
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
